matrix_input: RTL and testbench
===============================

Name: matrix_input

Overview:
- UART-side matrix entry engine; the receive-direction counterpart of the display/sender path.
- Collects raw-hex bytes from the UART receiver: M, then N, then M*N elements in row-major order.
- Validates dimensions and streams each element into matrix storage through a scalar write interface.
- Commits or aborts the matrix, then reports status to the top FSM and the 7-seg display.

Parameters:
- MAX_ROWS, 5, largest legal M
- MAX_COLS, 5, largest legal N
- DATA_WIDTH, 8, storage element width; each received byte is sign-extended to this width
- ROW_IDX_W, 3, row index width
- COL_IDX_W, 3, column index width
- TIMEOUT_CYCLES, 100000000, maximum idle cycles between element bytes

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start_en  in  1  level; high while top FSM is in input mode
- btn_quit  in  1  one-cycle pulse; leave input mode
- rx_data  in  8  received byte
- rx_done  in  1  one-cycle strobe; rx_data valid
- wr_begin  out  1  pulse; open a new matrix with wr_dims_r / wr_dims_c
- wr_dims_r  out  ROW_IDX_W  latched M
- wr_dims_c  out  COL_IDX_W  latched N
- wr_en  out  1  pulse; write wr_val at (wr_row, wr_col)
- wr_row  out  ROW_IDX_W  element row
- wr_col  out  COL_IDX_W  element column
- wr_val  out  DATA_WIDTH  sign-extended element
- wr_commit  out  1  pulse; matrix complete
- wr_abort  out  1  pulse; discard the open matrix
- busy  out  1  high from accepted M until commit or abort
- err_code  out  2  0 none, 1 bad dims, 2 timeout; holds until next accepted M
- input_done  out  1  pulse; leaving input mode

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- Input-mode entry:
  - IDLE -> GET_M when start_en=1.
  - Pulse outputs (wr_begin, wr_en, wr_commit, wr_abort, input_done) default to 0 every cycle.
- GET_M:
  - btn_quit -> pulse input_done, go to EXIT_WAIT.
  - rx_done -> latch byte as M, clear err_code, busy=1, go to GET_N.
- GET_N:
  - rx_done -> latch byte as N, go to CHECK_DIM.
  - btn_quit ignored.
- CHECK_DIM (1 cycle):
  - Legal if 1<=M<=MAX_ROWS and 1<=N<=MAX_COLS; compared on the full 8-bit byte, so 0x15 is illegal.
  - Legal -> pulse wr_begin with dims, clear row/col, go to GET_ELEM.
  - Illegal -> err_code=1, busy=0, back to GET_M; no storage activity.
- GET_ELEM:
  - Idle counter increments each cycle without rx_done and clears on rx_done.
  - rx_done -> latch the byte.
  - Next cycle (WRITE_ELEM): wr_en=1 with current row/col and wr_val={sign-extended byte}.
  - Element write latency is exactly 1 cycle after rx_done.
  - Cursor advance: col+1; at col=N-1, col=0 and row+1.
  - After the last element (row=M-1, col=N-1), go to COMMIT; otherwise return to GET_ELEM.
- COMMIT: pulse wr_commit, busy=0, go to GET_M (next matrix accepted without re-entering mode).
- Timeout:
  - Idle counter reaching TIMEOUT_CYCLES-1 in GET_ELEM -> pulse wr_abort, err_code=2, busy=0, go to GET_M.
- rx_done in non-receiving states (CHECK_DIM, WRITE_ELEM, COMMIT) is dropped. The UART byte time guarantees this never occurs in legal traffic.
- start_en falling while busy:
  - Pulse wr_abort, busy=0, go to IDLE the next cycle; input_done is not pulsed.
  - Not busy -> IDLE.
- EXIT_WAIT -> IDLE when start_en=0.
- Reset mid-matrix: everything returns to reset values; no abort pulse. Storage is reset by the same rst.

Optional Feature:
- Macro MATRIX_INPUT_ZERO_PAD_EN.
- Defined: a timeout in GET_ELEM does not abort. The block enters PAD:
  - writes 0 to each remaining cell, one wr_en per cycle, in row-major order;
  - then pulses wr_commit;
  - err_code=2 still reported.
- Undefined: timeout aborts as above.

Test Plan:
- Bytes 02,03,01,FF,02,03,04,05 -> wr_begin dims (2,3); six wr_en at (0,0)..(1,2) with values 1,-1,2,3,4,5; one wr_commit; err_code=0.
- Bytes 06,02 -> err_code=1, no wr_begin; then 01,01,07 -> commit, value 7, err_code cleared.
- TIMEOUT_CYCLES=50; bytes 02,02,09 then silence:
  - without macro: wr_abort exactly 50 cycles after the last rx_done, err_code=2;
  - with macro: writes 0 to (0,1),(1,0),(1,1) on three consecutive cycles, then wr_commit.
- Bytes 01,02,05, then start_en dropped -> wr_abort next cycle, busy=0, state IDLE.
- btn_quit in GET_M -> input_done pulse; start_en kept high stays in EXIT_WAIT; dropping it -> IDLE.
- Assert rst during element 3 of a 3x3 -> all outputs 0 next cycle; no commit or abort pulse.

Source files
------------

// File: rtl/matrix_input.sv
// UART-side matrix entry engine: collects M, N and M*N raw-hex bytes and streams them into storage.
// Optional MATRIX_INPUT_ZERO_PAD_EN: on timeout, zero-fill the remaining cells and commit instead of aborting.
module matrix_input #(
    parameter int unsigned MAX_ROWS       = 5,
    parameter int unsigned MAX_COLS       = 5,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ROW_IDX_W      = 3,
    parameter int unsigned COL_IDX_W      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_en,
    input  logic                  btn_quit,
    input  logic [7:0]            rx_data,
    input  logic                  rx_done,
    output logic                  wr_begin,
    output logic [ROW_IDX_W-1:0]  wr_dims_r,
    output logic [COL_IDX_W-1:0]  wr_dims_c,
    output logic                  wr_en,
    output logic [ROW_IDX_W-1:0]  wr_row,
    output logic [COL_IDX_W-1:0]  wr_col,
    output logic [DATA_WIDTH-1:0] wr_val,
    output logic                  wr_commit,
    output logic                  wr_abort,
    output logic                  busy,
    output logic [1:0]            err_code,
    output logic                  input_done
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_DIMS    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_GET_M,
        S_GET_N,
        S_CHECK_DIM,
        S_GET_ELEM,
        S_WRITE_ELEM,
        S_PAD,
        S_COMMIT,
        S_EXIT_WAIT
    } state_t;

    state_t                state_q, state_n;
    logic [7:0]            m_q, m_n;
    logic [7:0]            n_q, n_n;
    logic [ROW_IDX_W-1:0]  row_q, row_n, row_adv;
    logic [COL_IDX_W-1:0]  col_q, col_n, col_adv;
    logic [CNT_W-1:0]      cnt_q, cnt_n;

    logic                  wr_begin_n, wr_en_n, wr_commit_n, wr_abort_n, busy_n, input_done_n;
    logic [ROW_IDX_W-1:0]  wr_dims_r_n, wr_row_n;
    logic [COL_IDX_W-1:0]  wr_dims_c_n, wr_col_n;
    logic [DATA_WIDTH-1:0] wr_val_n;
    logic [1:0]            err_code_n;

    logic                  dims_ok, last_cell, timed_out;
    logic signed [7:0]     rx_byte_s;

    assign rx_byte_s = $signed(rx_data);
    assign dims_ok   = (m_q != 8'd0) && (m_q <= 8'(MAX_ROWS)) &&
                       (n_q != 8'd0) && (n_q <= 8'(MAX_COLS));
    assign timed_out = (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));

    // Row-major cursor advance within the latched dimensions
    always_comb begin
        last_cell = (row_q == wr_dims_r - ROW_IDX_W'(1)) && (col_q == wr_dims_c - COL_IDX_W'(1));
        if (col_q == wr_dims_c - COL_IDX_W'(1)) begin
            col_adv = '0;
            row_adv = row_q + ROW_IDX_W'(1);
        end else begin
            col_adv = col_q + COL_IDX_W'(1);
            row_adv = row_q;
        end
    end

    always_comb begin
        state_n      = state_q;
        m_n          = m_q;
        n_n          = n_q;
        row_n        = row_q;
        col_n        = col_q;
        cnt_n        = cnt_q;
        wr_begin_n   = 1'b0;
        wr_en_n      = 1'b0;
        wr_commit_n  = 1'b0;
        wr_abort_n   = 1'b0;
        input_done_n = 1'b0;
        wr_dims_r_n  = wr_dims_r;
        wr_dims_c_n  = wr_dims_c;
        wr_row_n     = wr_row;
        wr_col_n     = wr_col;
        wr_val_n     = wr_val;
        busy_n       = busy;
        err_code_n   = err_code;

        // Leaving input mode mid-matrix discards it without signalling input_done
        if (state_q != S_IDLE && !start_en) begin
            if (busy) begin
                wr_abort_n = 1'b1;
            end
            busy_n  = 1'b0;
            state_n = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_en) state_n = S_GET_M;
                end
                S_GET_M: begin
                    if (btn_quit) begin
                        input_done_n = 1'b1;
                        state_n      = S_EXIT_WAIT;
                    end else if (rx_done) begin
                        m_n        = rx_data;
                        err_code_n = ERR_NONE;
                        busy_n     = 1'b1;
                        state_n    = S_GET_N;
                    end
                end
                S_GET_N: begin
                    if (rx_done) begin
                        n_n     = rx_data;
                        state_n = S_CHECK_DIM;
                    end
                end
                S_CHECK_DIM: begin
                    if (dims_ok) begin
                        wr_begin_n  = 1'b1;
                        wr_dims_r_n = ROW_IDX_W'(m_q);
                        wr_dims_c_n = COL_IDX_W'(n_q);
                        row_n       = '0;
                        col_n       = '0;
                        cnt_n       = '0;
                        state_n     = S_GET_ELEM;
                    end else begin
                        err_code_n = ERR_DIMS;
                        busy_n     = 1'b0;
                        state_n    = S_GET_M;
                    end
                end
                S_GET_ELEM: begin
                    if (rx_done) begin
                        cnt_n    = '0;
                        wr_en_n  = 1'b1;
                        wr_row_n = row_q;
                        wr_col_n = col_q;
                        wr_val_n = DATA_WIDTH'(rx_byte_s);
                        state_n  = S_WRITE_ELEM;
                    end else if (timed_out) begin
                        err_code_n = ERR_TIMEOUT;
`ifdef MATRIX_INPUT_ZERO_PAD_EN
                        state_n    = S_PAD;
`else
                        wr_abort_n = 1'b1;
                        busy_n     = 1'b0;
                        state_n    = S_GET_M;
`endif
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end
                S_WRITE_ELEM: begin
                    cnt_n   = cnt_q + CNT_W'(1);
                    row_n   = row_adv;
                    col_n   = col_adv;
                    state_n = last_cell ? S_COMMIT : S_GET_ELEM;
                end
`ifdef MATRIX_INPUT_ZERO_PAD_EN
                // One zero write per cycle over the cells not yet received
                S_PAD: begin
                    wr_en_n  = 1'b1;
                    wr_row_n = row_q;
                    wr_col_n = col_q;
                    wr_val_n = '0;
                    row_n    = row_adv;
                    col_n    = col_adv;
                    if (last_cell) state_n = S_COMMIT;
                end
`endif
                S_COMMIT: begin
                    wr_commit_n = 1'b1;
                    busy_n      = 1'b0;
                    state_n     = S_GET_M;
                end
                S_EXIT_WAIT: begin
                    state_n = S_EXIT_WAIT;
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            m_q        <= '0;
            n_q        <= '0;
            row_q      <= '0;
            col_q      <= '0;
            cnt_q      <= '0;
            wr_begin   <= 1'b0;
            wr_dims_r  <= '0;
            wr_dims_c  <= '0;
            wr_en      <= 1'b0;
            wr_row     <= '0;
            wr_col     <= '0;
            wr_val     <= '0;
            wr_commit  <= 1'b0;
            wr_abort   <= 1'b0;
            busy       <= 1'b0;
            err_code   <= '0;
            input_done <= 1'b0;
        end else begin
            state_q    <= state_n;
            m_q        <= m_n;
            n_q        <= n_n;
            row_q      <= row_n;
            col_q      <= col_n;
            cnt_q      <= cnt_n;
            wr_begin   <= wr_begin_n;
            wr_dims_r  <= wr_dims_r_n;
            wr_dims_c  <= wr_dims_c_n;
            wr_en      <= wr_en_n;
            wr_row     <= wr_row_n;
            wr_col     <= wr_col_n;
            wr_val     <= wr_val_n;
            wr_commit  <= wr_commit_n;
            wr_abort   <= wr_abort_n;
            busy       <= busy_n;
            err_code   <= err_code_n;
            input_done <= input_done_n;
        end
    end

endmodule

// File: tb/tb_matrix_input.sv
// Directed bench for matrix_input: entry, bad dims, timeout (abort or zero-pad), mode exit and reset.
module tb_matrix_input;

    localparam int unsigned DW = 8;
    localparam int unsigned RW = 3;
    localparam int unsigned CW = 3;
    localparam int unsigned TO = 50;

    logic          clk = 1'b0;
    logic          rst, start_en, btn_quit, rx_done;
    logic [7:0]    rx_data;
    logic          wr_begin, wr_en, wr_commit, wr_abort, busy, input_done;
    logic [RW-1:0] wr_dims_r, wr_row;
    logic [CW-1:0] wr_dims_c, wr_col;
    logic [DW-1:0] wr_val;
    logic [1:0]    err_code;

    matrix_input #(
        .MAX_ROWS(5), .MAX_COLS(5), .DATA_WIDTH(DW),
        .ROW_IDX_W(RW), .COL_IDX_W(CW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .start_en(start_en), .btn_quit(btn_quit),
        .rx_data(rx_data), .rx_done(rx_done),
        .wr_begin(wr_begin), .wr_dims_r(wr_dims_r), .wr_dims_c(wr_dims_c),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_val(wr_val),
        .wr_commit(wr_commit), .wr_abort(wr_abort), .busy(busy),
        .err_code(err_code), .input_done(input_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RW-1:0] row;
        logic [CW-1:0] col;
        logic [DW-1:0] val;
        int            cyc;
    } wr_rec_t;

    wr_rec_t wq[$];
    int cyc, n_begin, n_commit, n_abort, n_done;
    int begin_r, begin_c, abort_cyc, commit_cyc, last_rx_cyc;
    int vectors, miscompares;

    // Advance one clock and log every output pulse seen after that edge
    task automatic step();
        wr_rec_t r;
        @(posedge clk);
        #1;
        cyc++;
        if (wr_en) begin
            r.row = wr_row; r.col = wr_col; r.val = wr_val; r.cyc = cyc;
            wq.push_back(r);
        end
        if (wr_begin)   begin n_begin++; begin_r = int'(wr_dims_r); begin_c = int'(wr_dims_c); end
        if (wr_commit)  begin n_commit++; commit_cyc = cyc; end
        if (wr_abort)   begin n_abort++; abort_cyc = cyc; end
        if (input_done) n_done++;
    endtask

    task automatic clear_log();
        wq.delete();
        n_begin = 0; n_commit = 0; n_abort = 0; n_done = 0;
        begin_r = -1; begin_c = -1; abort_cyc = -1; commit_cyc = -1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        step();
        last_rx_cyc = cyc;
        rx_done = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; start_en = 1'b0; btn_quit = 1'b0; rx_done = 1'b0; rx_data = 8'h00;
        repeat (2) step();
        vectors++;
        if ({wr_begin, wr_dims_r, wr_dims_c, wr_en, wr_row, wr_col, wr_val, wr_commit,
             wr_abort, busy, err_code, input_done} !== 28'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%b err=%0d wr_en=%b, required all zero", busy, err_code, wr_en);
        end
        rst = 1'b0;
        step();
        vectors++;
        if (busy !== 1'b0 || err_code !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_idle: got busy=%b err=%0d, required 0/0", busy, err_code);
        end
    endtask

    task automatic test_basic();
        logic [7:0] bytes[8] = '{8'h02, 8'h03, 8'h01, 8'hFF, 8'h02, 8'h03, 8'h04, 8'h05};
        int er[6] = '{0, 0, 0, 1, 1, 1};
        int ec[6] = '{0, 1, 2, 0, 1, 2};
        logic [7:0] ev[6] = '{8'h01, 8'hFF, 8'h02, 8'h03, 8'h04, 8'h05};
        int first_rx;
        clear_log();
        start_en = 1'b1;
        step();
        first_rx = -1;
        for (int i = 0; i < 8; i++) begin
            send(bytes[i]);
            if (i == 2) first_rx = last_rx_cyc;
        end
        repeat (3) step();
        vectors++;
        if (n_begin !== 1 || begin_r !== 2 || begin_c !== 3) begin
            miscompares++;
            $display("FAIL basic_begin: got %0d pulses dims (%0d,%0d), required 1 pulse dims (2,3)", n_begin, begin_r, begin_c);
        end
        vectors++;
        if (wq.size() !== 6) begin
            miscompares++;
            $display("FAIL basic_write_count: got %0d, required 6", wq.size());
        end
        for (int i = 0; i < 6 && i < wq.size(); i++) begin
            vectors++;
            if (wq[i].row !== RW'(er[i]) || wq[i].col !== CW'(ec[i]) || wq[i].val !== ev[i]) begin
                miscompares++;
                $display("FAIL basic_write%0d: got (%0d,%0d)=%h, required (%0d,%0d)=%h",
                         i, wq[i].row, wq[i].col, wq[i].val, er[i], ec[i], ev[i]);
            end
        end
        if (wq.size() > 0) begin
            vectors++;
            if (wq[0].cyc !== first_rx) begin
                miscompares++;
                $display("FAIL basic_latency: wr_en at cycle %0d, required %0d", wq[0].cyc, first_rx);
            end
        end
        vectors++;
        if (n_commit !== 1 || n_abort !== 0 || err_code !== 2'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_status: got commit=%0d abort=%0d err=%0d busy=%b, required 1/0/0/0",
                     n_commit, n_abort, err_code, busy);
        end
    endtask

    task automatic test_bad_dims();
        clear_log();
        send(8'h06);
        send(8'h02);
        step();
        vectors++;
        if (err_code !== 2'd1 || n_begin !== 0 || busy !== 1'b0 || wq.size() !== 0) begin
            miscompares++;
            $display("FAIL bad_dims: got err=%0d begin=%0d busy=%b writes=%0d, required 1/0/0/0",
                     err_code, n_begin, busy, wq.size());
        end
        send(8'h01);
        send(8'h01);
        send(8'h07);
        repeat (2) step();
        vectors++;
        if (n_begin !== 1 || n_commit !== 1 || wq.size() !== 1 || err_code !== 2'd0) begin
            miscompares++;
            $display("FAIL retry_1x1: got begin=%0d commit=%0d writes=%0d err=%0d, required 1/1/1/0",
                     n_begin, n_commit, wq.size(), err_code);
        end else begin
            vectors++;
            if (wq[0].row !== 3'd0 || wq[0].col !== 3'd0 || wq[0].val !== 8'h07) begin
                miscompares++;
                $display("FAIL retry_value: got (%0d,%0d)=%h, required (0,0)=07", wq[0].row, wq[0].col, wq[0].val);
            end
        end
    endtask

    task automatic test_timeout();
        clear_log();
        send(8'h02);
        send(8'h02);
        send(8'h09);
        for (int i = 0; i < 100 && n_abort == 0 && n_commit == 0; i++) step();
        step();
        vectors++;
        if (err_code !== 2'd2 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_status: got err=%0d busy=%b, required 2/0", err_code, busy);
        end
`ifdef MATRIX_INPUT_ZERO_PAD_EN
        vectors++;
        if (n_abort !== 0 || n_commit !== 1 || wq.size() !== 4) begin
            miscompares++;
            $display("FAIL pad_counts: got abort=%0d commit=%0d writes=%0d, required 0/1/4", n_abort, n_commit, wq.size());
        end else begin
            vectors++;
            if (wq[1].row !== 3'd0 || wq[1].col !== 3'd1 || wq[2].row !== 3'd1 || wq[2].col !== 3'd0 ||
                wq[3].row !== 3'd1 || wq[3].col !== 3'd1 || wq[1].val !== 8'h00 ||
                wq[2].val !== 8'h00 || wq[3].val !== 8'h00) begin
                miscompares++;
                $display("FAIL pad_cells: got (%0d,%0d)=%h (%0d,%0d)=%h (%0d,%0d)=%h, required (0,1)(1,0)(1,1) all 00",
                         wq[1].row, wq[1].col, wq[1].val, wq[2].row, wq[2].col, wq[2].val,
                         wq[3].row, wq[3].col, wq[3].val);
            end
            vectors++;
            if (wq[2].cyc !== wq[1].cyc + 1 || wq[3].cyc !== wq[2].cyc + 1 || commit_cyc <= wq[3].cyc) begin
                miscompares++;
                $display("FAIL pad_timing: got writes at %0d,%0d,%0d commit %0d, required consecutive then commit",
                         wq[1].cyc, wq[2].cyc, wq[3].cyc, commit_cyc);
            end
        end
`else
        vectors++;
        if (n_abort !== 1 || abort_cyc - last_rx_cyc !== 50) begin
            miscompares++;
            $display("FAIL timeout_abort: got %0d aborts at +%0d cycles, required 1 at +50", n_abort, abort_cyc - last_rx_cyc);
        end
        vectors++;
        if (n_commit !== 0 || wq.size() !== 1) begin
            miscompares++;
            $display("FAIL timeout_no_commit: got commit=%0d writes=%0d, required 0/1", n_commit, wq.size());
        end
`endif
    endtask

    task automatic test_start_drop();
        clear_log();
        send(8'h01);
        send(8'h02);
        send(8'h05);
        start_en = 1'b0;
        step();
        vectors++;
        if (wr_abort !== 1'b1 || busy !== 1'b0 || input_done !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_abort: got abort=%b busy=%b done=%b, required 1/0/0", wr_abort, busy, input_done);
        end
        step();
        vectors++;
        if (wr_abort !== 1'b0 || n_abort !== 1) begin
            miscompares++;
            $display("FAIL drop_pulse: got abort=%b count=%0d, required 0/1", wr_abort, n_abort);
        end
        send(8'h01);
        vectors++;
        if (busy !== 1'b0 || n_commit !== 0) begin
            miscompares++;
            $display("FAIL drop_idle: got busy=%b commit=%0d, required 0/0", busy, n_commit);
        end
    endtask

    task automatic test_quit();
        clear_log();
        start_en = 1'b1;
        step();
        btn_quit = 1'b1;
        step();
        btn_quit = 1'b0;
        vectors++;
        if (input_done !== 1'b1) begin
            miscompares++;
            $display("FAIL quit_done: got %b, required 1", input_done);
        end
        step();
        vectors++;
        if (input_done !== 1'b0 || n_done !== 1) begin
            miscompares++;
            $display("FAIL quit_pulse: got %b count=%0d, required 0/1", input_done, n_done);
        end
        repeat (5) step();
        send(8'h02);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL exit_wait_hold: got busy=%b, required 0", busy);
        end
        start_en = 1'b0;
        repeat (2) step();
        start_en = 1'b1;
        step();
        send(8'h02);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reentry: got busy=%b, required 1", busy);
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        step();
        rst = 1'b0;
        start_en = 1'b1;
        step();
        send(8'h03);
        send(8'h03);
        send(8'h0A);
        send(8'h0B);
        clear_log();
        rx_data = 8'h0C;
        rx_done = 1'b1;
        rst = 1'b1;
        step();
        rx_done = 1'b0;
        rst = 1'b0;
        vectors++;
        if ({wr_begin, wr_dims_r, wr_dims_c, wr_en, wr_row, wr_col, wr_val, wr_commit,
             wr_abort, busy, err_code, input_done} !== 28'd0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: got dims=(%0d,%0d) val=%h busy=%b wr_en=%b, required all zero",
                     wr_dims_r, wr_dims_c, wr_val, busy, wr_en);
        end
        repeat (10) step();
        vectors++;
        if (n_commit !== 0 || n_abort !== 0 || wq.size() !== 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_quiet: got commit=%0d abort=%0d writes=%0d busy=%b, required 0/0/0/0",
                     n_commit, n_abort, wq.size(), busy);
        end
    endtask

    initial begin
        cyc = 0; vectors = 0; miscompares = 0; last_rx_cyc = 0;
        clear_log();
        test_reset();
        test_basic();
        test_bad_dims();
        test_timeout();
        test_start_drop();
        test_quit();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
